// File: rtl/un_striping_pkg.sv
// Shared types and constants for the lane un-striping path: state encoding and word geometry.
package un_striping_pkg;

  localparam int LANE_W   = 32;
  localparam int LANE_CNT = 2;

  typedef logic [LANE_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_ALIGN  = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

endpackage

// File: rtl/unstripe_lane_fifo.sv
// Per-lane synchronous FIFO with push/pop/flush; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module unstripe_lane_fifo
  import un_striping_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk_2f,
  input  logic  reset,
  input  logic  push,
  input  word_t wr_data,
  input  logic  pop,
  input  logic  flush,
  output word_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  word_t       mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_2f) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_2f) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/unstripe_lane_scheduler.sv
// Re-merges two striped 32-bit lanes into one ordered stream (lane 0, lane 1, ...) with
// alignment FSM, per-lane FIFOs and output backpressure. Optional stats: UNSTRIPE_STATS_EN.
module unstripe_lane_scheduler
  import un_striping_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int STALL_MAX = 8
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [LANE_W-1:0] lane_0,
  input  logic              valid_0,
  input  logic [LANE_W-1:0] lane_1,
  input  logic              valid_1,
  input  logic              out_ready,
  output logic [LANE_W-1:0] data_out,
  output logic              valid_out,
  output logic              aligned,
  output logic [1:0]        overflow,
  output logic              lane_err,
  output logic [15:0]       words_out,
  output logic [7:0]        resyncs
);

  localparam int SW = $clog2(STALL_MAX + 1);

  state_t              state_q, state_d;
  logic                exp_q, exp_d;
  logic [SW-1:0]       stall_q, stall_d;

  word_t               lane_data [LANE_CNT];
  word_t               rd_data   [LANE_CNT];
  logic [LANE_CNT-1:0] lane_valid;
  logic [LANE_CNT-1:0] full, empty, push, pop, drop;
  logic                flush, load, xfer, out_free, resync_entry;

  assign lane_data[0] = lane_0;
  assign lane_data[1] = lane_1;
  assign lane_valid   = {valid_1, valid_0};

  assign xfer         = valid_out && out_ready;
  assign out_free     = !valid_out || xfer;
  assign aligned      = (state_q == ST_RUN);
  assign resync_entry = (state_d == ST_RESYNC) && (state_q != ST_RESYNC);

  // Lanes cannot be throttled: a word either lands in its FIFO or is counted as dropped.
  // Words arriving during the flush cycle are discarded without flagging overflow.
  always_comb begin
    for (int i = 0; i < LANE_CNT; i++) begin
      push[i] = lane_valid[i] && (!full[i] || pop[i]) && !flush;
      drop[i] = lane_valid[i] && !push[i] && !flush;
    end
  end

  for (genvar g = 0; g < LANE_CNT; g++) begin : g_fifo
    unstripe_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_2f  (clk_2f),
      .reset   (reset),
      .push    (push[g]),
      .wr_data (lane_data[g]),
      .pop     (pop[g]),
      .flush   (flush),
      .rd_data (rd_data[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    stall_d = stall_q;
    pop     = '0;
    flush   = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        exp_d = 1'b0;
        if (!empty[0]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!empty[exp_q] && out_free) begin
          pop[exp_q] = 1'b1;
          load       = 1'b1;
          exp_d      = ~exp_q;
          stall_d    = '0;
        end else if (empty[exp_q] && !empty[~exp_q]) begin
          // The other lane has data but ours does not: count toward a resync.
          stall_d = stall_q + SW'(1);
          if (stall_d == SW'(STALL_MAX)) state_d = ST_RESYNC;
        end
      end
      ST_RESYNC: begin
        flush   = 1'b1;
        stall_d = '0;
        exp_d   = 1'b0;
        state_d = ST_ALIGN;
      end
      default: state_d = ST_ALIGN;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q   <= ST_ALIGN;
      exp_q     <= 1'b0;
      stall_q   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= '0;
      lane_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      stall_q  <= stall_d;
      overflow <= overflow | drop;
      lane_err <= resync_entry;
      if (load) begin
        data_out  <= rd_data[exp_q];
        valid_out <= 1'b1;
      end else if (out_free) begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end
    end
  end

`ifdef UNSTRIPE_STATS_EN
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      words_out <= '0;
      resyncs   <= '0;
    end else begin
      if (xfer) words_out <= words_out + 16'd1;
      if (resync_entry && resyncs != 8'hFF) resyncs <= resyncs + 8'd1;
    end
  end
`else
  assign words_out = '0;
  assign resyncs   = '0;
`endif

endmodule
